// File: rtl/stopwatch_display_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_display_scan_pkg
// Description : Shared constants and types for the stopwatch display scanner.
//               Segment vectors are active-low with a..g mapped to bit 1..7.
//               The shared items are the blank and dash patterns, the 0-9
//               digit table, the digit count, the 2-bit digit index type and
//               the anode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_display_scan_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:1] SEG_BLANK = 7'h7F;
    // Only segment g lit.
    localparam logic [7:1] SEG_DASH  = 7'h3F;

    // Active-low patterns for digits 0..9, bit 7 = g .. bit 1 = a.
    localparam logic [7:1] DIGIT_SEG [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t IDX_MIN_UNITS = 2'd2;
    localparam digit_idx_t IDX_MIN_TENS  = 2'd3;

    // Active-low anode enable for a single digit slot.
    function automatic logic [4:1] anode_for(input digit_idx_t idx);
        logic [4:1] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_display_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_display_scan_if
// Description : Bundle between the stopwatch time bus and the display.
//               The master (stopwatch side) drives Q_in, BLINK and LZ_BLANK.
//               The slave (scanner) drives SEG, DP, AN and FRAME.
//   Q_in     [16:1] BCD MM:SS, [4:1]=s units .. [16:13]=min tens
//   BLINK           flash whole display
//   LZ_BLANK        blank min-tens digit when it is zero
//   SEG      [7:1]  segments a..g, active-low
//   DP              decimal point / colon, active-low
//   AN       [4:1]  digit enables, AN[1]=s units, active-low
//   FRAME           one-cycle pulse when a new snapshot is loaded
// Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_display_scan_if;
    logic [16:1] Q_in;
    logic        BLINK;
    logic        LZ_BLANK;
    logic [7:1]  SEG;
    logic        DP;
    logic [4:1]  AN;
    logic        FRAME;

    modport master (
        output Q_in, BLINK, LZ_BLANK,
        input  SEG, DP, AN, FRAME
    );

    modport slave (
        input  Q_in, BLINK, LZ_BLANK,
        output SEG, DP, AN, FRAME
    );
endinterface
`default_nettype wire

// File: rtl/stopwatch_display_scan_bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational BCD to active-low 7-segment decoder. Nibbles
//               10..15 are not valid BCD and show a dash.
//   i_bcd [3:0]  BCD digit
//   o_seg [7:1]  segments a..g, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import stopwatch_display_scan_pkg::*;
(
    input  wire logic [3:0] i_bcd,
    output logic      [7:1] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        if (i_bcd <= 4'd9) begin
            o_seg = DIGIT_SEG[i_bcd];
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_display_scan
// Description : Scans the four BCD digits of the stopwatch time bus onto a
//               common-anode 4-digit 7-segment display. The time is
//               snapshotted once per frame so a frame never tears. Each slot
//               starts with an all-off guard window. The block also supports
//               whole-display blink and min-tens leading-zero blanking.
//   clk_in          system clock, rising edge
//   RESET_n         asynchronous active-low reset
//   bus (slave)     Q_in/BLINK/LZ_BLANK in, SEG/DP/AN/FRAME out
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_display_scan
    import stopwatch_display_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int GUARD     = 8,
    parameter int BLINK_DIV = 64
) (
    input  wire logic                 clk_in,
    input  wire logic                 RESET_n,
    stopwatch_display_scan_if.slave   bus
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    // Scan state
    logic [PRE_W-1:0] prescaler_q, prescaler_d;
    digit_idx_t       idx_q, idx_d;
    logic [16:1]      snapshot_q, snapshot_d;
    // Set by reset. It marks the first cycle after release so that this
    // cycle also starts a frame.
    logic             first_q, first_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             hidden_q, hidden_d;

    // Registered outputs
    logic [7:1]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [4:1]       an_q, an_d;
    logic             frame_q, frame_d;

    logic             w_wrap;
    logic             w_frame_start;
    logic             w_guard;
    logic             w_lz_blank;
    logic [3:0]       w_digit;
    logic [7:1]       w_digit_seg;

    generate
        if (GUARD == 0) begin : g_no_guard
            assign w_guard = 1'b0;
        end else begin : g_guard
            assign w_guard = (prescaler_q < PRE_W'(GUARD));
        end
    endgenerate

    always_comb begin
        w_digit = snapshot_q[4:1];
        case (idx_q)
            2'd1:    w_digit = snapshot_q[8:5];
            2'd2:    w_digit = snapshot_q[12:9];
            2'd3:    w_digit = snapshot_q[16:13];
            default: w_digit = snapshot_q[4:1];
        endcase
    end

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_digit_seg)
    );

    // Next-state: prescaler, digit index, snapshot and blink counters.
    always_comb begin
        w_wrap        = (prescaler_q == PRE_LAST);
        w_frame_start = first_q | (w_wrap & (idx_q == IDX_MIN_TENS));

        prescaler_d = w_wrap ? '0 : prescaler_q + 1'b1;
        idx_d       = w_wrap ? idx_q + 2'd1 : idx_q;
        first_d     = 1'b0;
        snapshot_d  = w_frame_start ? bus.Q_in : snapshot_q;
        frame_cnt_d = frame_cnt_q;
        hidden_d    = hidden_q;
        frame_d     = w_frame_start;

        if (w_frame_start) begin
            if (!bus.BLINK) begin
                frame_cnt_d = '0;
                hidden_d    = 1'b0;
            end else if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                hidden_d    = ~hidden_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Slot output, registered one cycle behind prescaler/idx. The first cycle
    // after reset release is blanked like a guard cycle. During that cycle
    // the snapshot still holds its reset value.
    always_comb begin
        w_lz_blank = (idx_q == IDX_MIN_TENS) & bus.LZ_BLANK
                     & (snapshot_q[16:13] == 4'd0);

        an_d  = 4'hF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;

        if (!(first_q | w_guard)) begin
            dp_d = (idx_q != IDX_MIN_UNITS);
            if (!w_lz_blank) begin
                an_d  = anode_for(idx_q);
                seg_d = w_digit_seg;
            end
            // Blink gates only the anodes; BLINK is read live, so a change
            // shows on the next cycle without waiting for a frame.
            if (bus.BLINK & hidden_q) begin
                an_d = 4'hF;
            end
        end
    end

    always_ff @(posedge clk_in or negedge RESET_n) begin
        if (!RESET_n) begin
            prescaler_q <= '0;
            idx_q       <= '0;
            snapshot_q  <= '0;
            first_q     <= 1'b1;
            frame_cnt_q <= '0;
            hidden_q    <= 1'b0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            an_q        <= 4'hF;
            frame_q     <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            snapshot_q  <= snapshot_d;
            first_q     <= first_d;
            frame_cnt_q <= frame_cnt_d;
            hidden_q    <= hidden_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.SEG   = seg_q;
    assign bus.DP    = dp_q;
    assign bus.AN    = an_q;
    assign bus.FRAME = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_display_scan
// Description : Self-checking bench for stopwatch_display_scan. A cycle-count
//               reference model derives the expected slot, digit and frame
//               from elapsed time since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_display_scan;

    localparam int SCAN_DIV  = 4;
    localparam int GUARD     = 1;
    localparam int BLINK_DIV = 2;
    localparam int FRAME_LEN = 4 * SCAN_DIV;

    logic clk_in = 1'b0;
    logic RESET_n;

    stopwatch_display_scan_if sw_if ();

    stopwatch_display_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .GUARD     (GUARD),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk_in  (clk_in),
        .RESET_n (RESET_n),
        .bus     (sw_if.slave)
    );

    always #5 clk_in = ~clk_in;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int          m_k;       // rising edges since reset release
    logic [15:0] m_snap;    // time shown in the current frame
    int          m_fc;      // frames counted in this blink half-period
    bit          m_hidden;
    bit          rand_mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t k=%0d: got=%h expected=%h", tag, $time, m_k, got, exp);
        end
    endtask

    // Segment pattern from the list of lit segments of each digit.
    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        string      lit;
        logic [6:0] s;
        s = 7'h7F;
        case (nib)
            4'd0:    lit = "abcdef";
            4'd1:    lit = "bc";
            4'd2:    lit = "abdeg";
            4'd3:    lit = "abcdg";
            4'd4:    lit = "bcfg";
            4'd5:    lit = "acdfg";
            4'd6:    lit = "acdefg";
            4'd7:    lit = "abc";
            4'd8:    lit = "abcdefg";
            4'd9:    lit = "abcdfg";
            default: lit = "g";
        endcase
        for (int i = 0; i < lit.len(); i++) begin
            s[int'(lit[i]) - 97] = 1'b0;
        end
        return s;
    endfunction

    function automatic logic [15:0] rand_time();
        logic [15:0] v;
        for (int n = 0; n < 4; n++) begin
            if ($urandom_range(0, 15) < 13) v[n*4 +: 4] = 4'($urandom_range(0, 9));
            else                            v[n*4 +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    task automatic reset_model();
        m_k      = 0;
        m_snap   = 16'h0000;
        m_fc     = 0;
        m_hidden = 1'b0;
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_AN"},    32'(sw_if.AN),    32'hF);
        chk({tag, "_SEG"},   32'(sw_if.SEG),   32'h7F);
        chk({tag, "_DP"},    32'(sw_if.DP),    32'h1);
        chk({tag, "_FRAME"}, 32'(sw_if.FRAME), 32'h0);
    endtask

    task automatic step_and_check();
        int         t, p, idx;
        bit         blank, fstart;
        logic [3:0] nib, exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;

        @(posedge clk_in);
        m_k++;
        // Outputs after edge k describe the state that held before it.
        t     = m_k - 1;
        p     = t % SCAN_DIV;
        idx   = (t / SCAN_DIV) % 4;
        blank = (t == 0) || (p < GUARD);
        nib   = m_snap[idx*4 +: 4];

        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
        if (!blank) begin
            exp_dp = (idx == 2) ? 1'b0 : 1'b1;
            if (!(idx == 3 && sw_if.LZ_BLANK && nib == 4'd0)) begin
                exp_an  = ~(4'b0001 << idx);
                exp_seg = seg_of(nib);
            end
            if (sw_if.BLINK && m_hidden) exp_an = 4'hF;
        end

        fstart = (m_k == 1) || (m_k % FRAME_LEN == 0);
        if (fstart) begin
            m_snap = sw_if.Q_in;
            if (!sw_if.BLINK) begin
                m_fc     = 0;
                m_hidden = 1'b0;
            end else begin
                m_fc++;
                if (m_fc == BLINK_DIV) begin
                    m_fc     = 0;
                    m_hidden = !m_hidden;
                end
            end
        end

        #1;
        chk("AN",        32'(sw_if.AN),    32'(exp_an));
        chk("SEG",       32'(sw_if.SEG),   32'(exp_seg));
        chk("DP",        32'(sw_if.DP),    32'(exp_dp));
        chk("FRAME",     32'(sw_if.FRAME), 32'(fstart));
        chk("AN_ONEHOT", 32'($countones(~sw_if.AN) <= 1), 32'h1);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step_and_check();
            @(negedge clk_in);
            if (rand_mode) begin
                if ($urandom_range(0, 19) == 0)  sw_if.Q_in     = rand_time();
                if ($urandom_range(0, 99) == 0)  sw_if.LZ_BLANK = ~sw_if.LZ_BLANK;
                if ($urandom_range(0, 199) == 0) sw_if.BLINK    = ~sw_if.BLINK;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sw_if.Q_in     = 16'h1020;
        sw_if.BLINK    = 1'b0;
        sw_if.LZ_BLANK = 1'b0;
        rand_mode      = 1'b0;
        reset_model();
        RESET_n = 1'b1;
        #1 RESET_n = 1'b0;
        #3 chk_blank("RESET");

        @(negedge clk_in);
        @(negedge clk_in);
        RESET_n = 1'b1;

        // Two frames of 10:20
        run(2 * FRAME_LEN);

        // Mid-frame change lands only on the following frame
        sw_if.Q_in = 16'h0059;
        run(FRAME_LEN + 6);
        sw_if.Q_in = 16'h0100;
        run(FRAME_LEN - 6 + FRAME_LEN);

        // Leading-zero blanking on and off
        sw_if.Q_in     = 16'h0930;
        sw_if.LZ_BLANK = 1'b1;
        run(2 * FRAME_LEN);
        sw_if.LZ_BLANK = 1'b0;
        run(2 * FRAME_LEN);

        // Illegal nibble dash plus blink
        sw_if.Q_in  = 16'hA000;
        sw_if.BLINK = 1'b1;
        run(8 * FRAME_LEN);
        sw_if.BLINK = 1'b0;
        run(2 * FRAME_LEN);

        // Random traffic
        rand_mode = 1'b1;
        run(1600);

        // Reset in the middle of a slot
        @(posedge clk_in);
        #3 RESET_n = 1'b0;
        #1 chk_blank("MIDRESET");
        reset_model();
        @(negedge clk_in);
        @(negedge clk_in);
        sw_if.Q_in = rand_time();
        RESET_n = 1'b1;
        run(400);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
